regfile_dump_unit: RTL

//  Reader-side companion to mips_registers: walks a register range through one read

---
 rtl/regfile_dump_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_dump_unit.sv
// Streams (address, data) pairs for a register range read through one register-file read port.
// Each word is fetched in one cycle and then held on a valid/ready output until it is accepted.
module regfile_dump_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] read_reg,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StAddr, StHold, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    last_flag_q, last_flag_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    data_d      = data_q;
    addr_d      = addr_q;
    last_flag_d = last_flag_q;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            last_d  = last_reg;
            cur_d   = first_reg;
            state_d = StAddr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        data_d      = read_data;
        addr_d      = cur_q;
        last_flag_d = (cur_q == last_q);
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready) begin
          // Only advance while cur < last, so the index never wraps at NUM_REGS-1.
          if (last_flag_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + ADDR_WIDTH'(1);
            state_d = StAddr;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      last_q      <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      last_flag_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      last_flag_q <= last_flag_d;
      err_q       <= err_d;
    end
  end

  // cur_q only changes on entry to ADDR, so read_reg holds its last value elsewhere.
  assign read_reg  = cur_q;
  assign out_valid = (state_q == StHold);
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_flag_q & out_valid;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;

endmodule
